ahb_aes_subordinate: RTL and testbench

AHB_AES_SUBORDINATE -- requirements
Module: ahb_aes_subordinate

---
 rtl/ahb_aes_subordinate.sv | 199 +++++++++++++++++++
 tb/tb_ahb_aes_subordinate.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_aes_subordinate.sv
// AHB-Lite subordinate exposing a memory-mapped register file in front of an AES core.
// Handles key/data staging, start handshake with done/timeout tracking and two-cycle ERROR responses.
module ahb_aes_subordinate #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         hclk,
    input  logic         hrstn,
    input  logic         hsel,
    input  logic [31:0]  haddr,
    input  logic [1:0]   htrans,
    input  logic         hwrite,
    input  logic [2:0]   hsize,
    input  logic [2:0]   hburst,
    input  logic [31:0]  hwdata,
    input  logic         hready,
    output logic [31:0]  hrdata,
    output logic         hreadyOut,
    output logic         hresp,
    output logic         aes_start,
    output logic [127:0] aes_key,
    output logic [127:0] aes_din,
    input  logic         aes_done,
    input  logic [127:0] aes_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ERR1,
        ERR2,
        RUN
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] IDX_STATUS = 4'h8;
    localparam logic [3:0] IDX_START  = 4'hB;

    state_t state_q, state_d;

    logic [31:0]      key_q  [4];
    logic [31:0]      din_q  [4];
    logic [31:0]      dout_q [4];
    logic             busy_q, done_q, tmo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             wr_pend_q, rd_pend_q;
    logic [3:0]       dp_idx_q;

    logic       addr_valid, accept, illegal, burst_bad;
    logic [3:0] idx;
    logic       start_req, wr_en, rd_en;
    logic       run_done, run_tmo;
    logic       unused_trans_lsb;

    assign unused_trans_lsb = htrans[0];

    // Address phase decode; new transfers are only taken while no response is in flight.
    assign addr_valid = hsel & hready & htrans[1];
    assign accept     = addr_valid & (state_q == IDLE);
    assign burst_bad  = !(hburst inside {3'd0, 3'd3, 3'd5});
    assign illegal    = (haddr > 32'h0000_003C) | (hsize != 3'b010) | burst_bad;
    assign idx        = haddr[5:2];

    assign start_req = accept & !illegal & hwrite & (idx == IDX_START);
    assign wr_en     = accept & !illegal & hwrite & (idx != IDX_START);
    assign rd_en     = accept & !illegal & !hwrite;

    // aes_done wins over the terminal count when both land in the same cycle.
    assign run_done = (state_q == RUN) & aes_done;
    assign run_tmo  = (state_q == RUN) & !aes_done & (cnt_q == CNT_TERM);

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hreadyOut = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && illegal) begin
                    state_d = ERR1;
                end else if (start_req) begin
                    state_d = RUN;
                end
            end
            ERR1: begin
                hreadyOut = 1'b0;
                hresp     = 1'b1;
                state_d   = ERR2;
            end
            ERR2: begin
                hresp   = 1'b1;
                state_d = IDLE;
            end
            RUN: begin
                hreadyOut = 1'b0;
                if (run_done) begin
                    state_d = IDLE;
                end else if (run_tmo) begin
                    state_d = ERR1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            dp_idx_q  <= '0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wr_pend_q <= wr_en;
            rd_pend_q <= rd_en;
            if (accept) begin
                dp_idx_q <= idx;
            end
            start_q <= start_req;
            if (start_req) begin
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Write data is taken in the data phase; addresses outside KEY/DIN fall through silently.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            for (int unsigned i = 0; i < 4; i++) begin
                key_q[i] <= '0;
                din_q[i] <= '0;
            end
        end else if (wr_pend_q) begin
            case (dp_idx_q[3:2])
                2'd0:    key_q[dp_idx_q[1:0]] <= hwdata;
                2'd1:    din_q[dp_idx_q[1:0]] <= hwdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            for (int unsigned i = 0; i < 4; i++) begin
                dout_q[i] <= '0;
            end
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            if (start_req) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
                tmo_q  <= 1'b0;
            end
            if (run_done) begin
                dout_q[0] <= aes_dout[127:96];
                dout_q[1] <= aes_dout[95:64];
                dout_q[2] <= aes_dout[63:32];
                dout_q[3] <= aes_dout[31:0];
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
            end else if (run_tmo) begin
                tmo_q  <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    always_comb begin
        hrdata = '0;
        if (rd_pend_q) begin
            case (dp_idx_q[3:2])
                2'd0: hrdata = key_q[dp_idx_q[1:0]];
                2'd1: hrdata = din_q[dp_idx_q[1:0]];
                2'd2: begin
                    if (dp_idx_q == IDX_STATUS) begin
                        hrdata = {29'd0, tmo_q, done_q, busy_q};
                    end
                end
                default: hrdata = dout_q[dp_idx_q[1:0]];
            endcase
        end
    end

    assign aes_start = start_q;
    assign aes_key   = {key_q[0], key_q[1], key_q[2], key_q[3]};
    assign aes_din   = {din_q[0], din_q[1], din_q[2], din_q[3]};

endmodule

// File: tb/tb_ahb_aes_subordinate.sv
// Directed bench for ahb_aes_subordinate: one instance with the default timeout, one with 16 cycles.
module tb_ahb_aes_subordinate;

    localparam logic [127:0] KEY_VEC  = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
    localparam logic [127:0] DIN_VEC  = 128'h3243F6A8_885A308D_313198A2_E0370734;
    localparam logic [127:0] DOUT_VEC = 128'h3925841D_02DC09FB_DC118597_196A0B32;
    localparam logic [127:0] ALT_VEC  = 128'hA5A5_0001_5A5A_0002_C3C3_0003_3C3C_0004;

    logic hclk = 1'b0;
    logic hrstn;
    always #5 hclk = ~hclk;

    logic         hsel_a, hsel_b;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize, hburst;
    logic [31:0]  hwdata;
    logic         aes_done;
    logic [127:0] aes_dout;

    logic         hready_a, hready_b;
    logic [31:0]  hrdata_a, hrdata_b;
    logic         hreadyOut_a, hreadyOut_b, hresp_a, hresp_b;
    logic         aes_start_a, aes_start_b;
    logic [127:0] aes_key_a, aes_key_b, aes_din_a, aes_din_b;

    assign hready_a = hreadyOut_a;
    assign hready_b = hreadyOut_b;

    ahb_aes_subordinate dut_a (
        .hclk(hclk), .hrstn(hrstn), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready_a),
        .hrdata(hrdata_a), .hreadyOut(hreadyOut_a), .hresp(hresp_a), .aes_start(aes_start_a),
        .aes_key(aes_key_a), .aes_din(aes_din_a), .aes_done(aes_done), .aes_dout(aes_dout)
    );

    ahb_aes_subordinate #(.TIMEOUT_CYCLES(16)) dut_b (
        .hclk(hclk), .hrstn(hrstn), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready_b),
        .hrdata(hrdata_b), .hreadyOut(hreadyOut_b), .hresp(hresp_b), .aes_start(aes_start_b),
        .aes_key(aes_key_b), .aes_din(aes_din_b), .aes_done(aes_done), .aes_dout(aes_dout)
    );

    logic         use_b;
    logic [31:0]  hrdata_m;
    logic         hreadyOut_m, hresp_m, aes_start_m;
    logic [127:0] aes_key_m, aes_din_m;

    assign hrdata_m    = use_b ? hrdata_b    : hrdata_a;
    assign hreadyOut_m = use_b ? hreadyOut_b : hreadyOut_a;
    assign hresp_m     = use_b ? hresp_b     : hresp_a;
    assign aes_start_m = use_b ? aes_start_b : aes_start_a;
    assign aes_key_m   = use_b ? aes_key_b   : aes_key_a;
    assign aes_din_m   = use_b ? aes_din_b   : aes_din_a;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        haddr = '0; hsize = 3'b010; hburst = 3'b000;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [2:0] bu);
        hsel_a = !use_b; hsel_b = use_b; htrans = 2'b10;
        haddr = a; hwrite = w; hsize = sz; hburst = bu;
        @(posedge hclk); #1;
        idle_bus();
    endtask

    task automatic ahb_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1, 3'b010, 3'b000);
        hwdata = d;
        check({tag, " wr okay"}, {hreadyOut_m, hresp_m}, 2'b10);
        @(posedge hclk); #1;
    endtask

    // Expected read data goes into the scoreboard at the address phase and is retired in the data phase.
    task automatic ahb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        addr_phase(a, 1'b0, 3'b010, 3'b000);
        check({tag, " rd okay"}, {hreadyOut_m, hresp_m}, 2'b10);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, hrdata_m, e);
        @(posedge hclk); #1;
    endtask

    task automatic illegal(input string tag, input logic [31:0] a, input logic [2:0] sz,
                           input logic [2:0] bu);
        addr_phase(a, 1'b1, sz, bu);
        hwdata = 32'hFFFF_FFFF;
        check({tag, " err1"}, {hresp_m, hreadyOut_m}, 2'b10);
        @(posedge hclk); #1;
        check({tag, " err2"}, {hresp_m, hreadyOut_m}, 2'b11);
        @(posedge hclk); #1;
        check({tag, " after"}, {hresp_m, hreadyOut_m}, 2'b01);
    endtask

    // done_at: RUN cycle (1 = the aes_start cycle) in which aes_done pulses; 0 means never.
    task automatic do_start(input string tag, input int done_at, input int tmo,
                            input logic [127:0] dv);
        bit stall_ok;
        bit pulse_ok;
        int limit;
        stall_ok = 1'b1;
        pulse_ok = 1'b1;
        limit = (done_at > 0) ? done_at : tmo;
        addr_phase(32'h2C, 1'b1, 3'b010, 3'b000);
        hwdata = 32'h1;
        for (int c = 1; c <= limit; c++) begin
            if (c == done_at) begin
                aes_done = 1'b1;
                aes_dout = dv;
            end
            if (aes_start_m !== (c == 1)) pulse_ok = 1'b0;
            if (hreadyOut_m !== 1'b0 || hrdata_m !== 32'h0) stall_ok = 1'b0;
            @(posedge hclk); #1;
            aes_done = 1'b0;
        end
        check({tag, " start pulse"}, pulse_ok, 1);
        check({tag, " stall"}, stall_ok, 1);
        if (done_at > 0) begin
            check({tag, " okay"}, {hresp_m, hreadyOut_m}, 2'b01);
        end else begin
            check({tag, " tmo err1"}, {hresp_m, hreadyOut_m}, 2'b10);
            @(posedge hclk); #1;
            check({tag, " tmo err2"}, {hresp_m, hreadyOut_m}, 2'b11);
            @(posedge hclk); #1;
        end
    endtask

    initial begin
        logic [127:0] v;
        use_b = 1'b0;
        idle_bus();
        hwdata = '0; aes_done = 1'b0; aes_dout = '0;
        hrstn = 1'b0;
        #1;
        check("rst ready", hreadyOut_m, 1);
        check("rst resp", hresp_m, 0);
        check("rst hrdata", hrdata_m, 0);
        check("rst start", aes_start_m, 0);
        check("rst key", aes_key_m, 0);
        repeat (2) @(posedge hclk);
        #1 hrstn = 1'b1;
        @(posedge hclk); #1;

        v = KEY_VEC;
        for (int i = 0; i < 4; i++) ahb_write("key", 32'(i * 4), v[127 - 32 * i -: 32]);
        check("aes_key", aes_key_m, KEY_VEC);
        for (int i = 0; i < 4; i++) ahb_read("key rb", 32'(i * 4), v[127 - 32 * i -: 32]);
        check("hrdata idle", hrdata_m, 0);
        v = DIN_VEC;
        for (int i = 0; i < 4; i++) ahb_write("din", 32'(16 + i * 4), v[127 - 32 * i -: 32]);
        check("aes_din", aes_din_m, DIN_VEC);
        ahb_read("din1 rb", 32'h14, 32'h885A308D);

        ahb_read("status init", 32'h20, 32'h0);
        ahb_write("status ro", 32'h20, 32'hFFFF_FFFF);
        ahb_read("status ro rb", 32'h20, 32'h0);
        ahb_write("rsvd", 32'h24, 32'hFFFF_FFFF);
        ahb_read("rsvd rb", 32'h24, 32'h0);
        ahb_write("dout ro", 32'h30, 32'h1234_5678);
        ahb_read("dout ro rb", 32'h30, 32'h0);
        ahb_read("addr lsb ignored", 32'h07, 32'h28AED2A6);

        illegal("ill addr", 32'h40, 3'b010, 3'b000);
        ahb_read("ill addr key0", 32'h00, 32'h2B7E1516);
        illegal("ill size", 32'h04, 3'b001, 3'b000);
        ahb_read("ill size key1", 32'h04, 32'h28AED2A6);
        illegal("ill burst", 32'h10, 3'b010, 3'b010);
        ahb_read("ill burst din0", 32'h10, 32'h3243F6A8);
        check("ill aes_key", aes_key_m, KEY_VEC);

        do_start("start", 40, 0, DOUT_VEC);
        v = DOUT_VEC;
        for (int i = 0; i < 4; i++) ahb_read("dout", 32'(48 + i * 4), v[127 - 32 * i -: 32]);
        ahb_read("status done", 32'h20, 32'h2);
        ahb_read("start reads 0", 32'h2C, 32'h0);

        addr_phase(32'h2C, 1'b1, 3'b010, 3'b000);
        check("rst-run start", aes_start_m, 1);
        repeat (9) begin @(posedge hclk); #1; end
        check("rst-run stalled", hreadyOut_m, 0);
        #2 hrstn = 1'b0;
        #1;
        check("rst-run ready", hreadyOut_m, 1);
        check("rst-run resp", hresp_m, 0);
        check("rst-run start0", aes_start_m, 0);
        check("rst-run key", aes_key_m, 0);
        check("rst-run din", aes_din_m, 0);
        #1 hrstn = 1'b1;
        @(posedge hclk); #1;
        ahb_read("post-rst dout0", 32'h30, 32'h0);
        ahb_read("post-rst status", 32'h20, 32'h0);
        ahb_read("post-rst key0", 32'h00, 32'h0);
        do_start("restart", 40, 0, DOUT_VEC);
        v = DOUT_VEC;
        for (int i = 0; i < 4; i++) ahb_read("re dout", 32'(48 + i * 4), v[127 - 32 * i -: 32]);
        ahb_read("re status", 32'h20, 32'h2);

        use_b = 1'b1;
        do_start("prio", 16, 16, ALT_VEC);
        ahb_read("prio status", 32'h20, 32'h2);
        ahb_read("prio dout0", 32'h30, 32'hA5A50001);
        do_start("tmo", 0, 16, '0);
        ahb_read("tmo status", 32'h20, 32'h4);
        v = ALT_VEC;
        for (int i = 0; i < 4; i++) ahb_read("tmo dout", 32'(48 + i * 4), v[127 - 32 * i -: 32]);
        ahb_write("tmo key0", 32'h00, 32'hCAFE_F00D);
        ahb_read("tmo key0 rb", 32'h00, 32'hCAFE_F00D);

        check("scoreboard drained", 128'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
